imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_ext_pkg.sv | 22 ++
 rtl/imm_ext_core.sv | 50 +++++
 rtl/imm_extend_pipe.sv | 121 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pkg
// Purpose  : Shared types and constants for the immediate-extension pipeline.
//            Holds the extension-mode encoding and its width.
// Contents : c_MODE_W  - width of the mode field
//            mode_t    - ZERO / SIGN / HIGH / BRANCH extension modes
// Revision : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    localparam int c_MODE_W = 2;

    typedef enum logic [c_MODE_W-1:0] {
        ZERO   = 2'b00,  // zero-extend
        SIGN   = 2'b01,  // sign-extend from the top input bit
        HIGH   = 2'b10,  // place immediate in the top bits (LUI form)
        BRANCH = 2'b11   // sign-extend, then scale by 4
    } mode_t;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_core
// Purpose  : Purely combinational immediate extension. Produces one of four
//            OUT_W-bit forms of an IN_W-bit immediate, selected by mode.
// Params   : IN_W  - immediate width (>= 1)
//            OUT_W - result width (>= IN_W + 2)
// Ports    : i_data [IN_W-1:0]  raw immediate
//            i_mode mode_t      extension mode
//            o_data [OUT_W-1:0] extended immediate
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  i_data,
    input  mode_t            i_mode,
    output logic [OUT_W-1:0] o_data
);

    localparam int c_PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] w_zero;
    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_high;
    logic [OUT_W-1:0] w_branch;

    assign w_zero   = {{c_PAD_W{1'b0}}, i_data};
    assign w_sign   = {{c_PAD_W{i_data[IN_W-1]}}, i_data};
    assign w_high   = {i_data, {c_PAD_W{1'b0}}};
    // Shift drops the two top sign copies; OUT_W >= IN_W + 2 keeps the
    // original sign bit within the result.
    assign w_branch = w_sign << 2;

    always_comb begin
        o_data = w_zero;
        case (i_mode)
            ZERO:    o_data = w_zero;
            SIGN:    o_data = w_sign;
            HIGH:    o_data = w_high;
            BRANCH:  o_data = w_branch;
            default: o_data = w_zero;
        endcase
    end

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Valid/ready pipeline stage wrapping imm_ext_core. One cycle of
//            latency, full throughput, results leave in acceptance order.
// Params   : IN_W  - immediate width (>= 1)
//            OUT_W - result width (>= IN_W + 2)
// Macro    : IMM_EXTEND_SKID_EN
//              defined   - two-entry skid buffer, ready_o is a flop output
//                          with no combinational path from ready_i
//              undefined - single output register,
//                          ready_o = !valid_o || ready_i
// Ports    : clk_i    in   clock, rising edge
//            rst_i    in   asynchronous active-low reset
//            valid_i  in   upstream immediate valid
//            ready_o  out  stage can accept this cycle
//            data_i   in   [IN_W]  raw immediate
//            mode_i   in   [2]     extension mode, sampled with data_i
//            valid_o  out  data_o holds a result
//            ready_i  in   downstream accepts data_o
//            data_o   out  [OUT_W] extended immediate
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [IN_W-1:0]     data_i,
    input  logic [c_MODE_W-1:0] mode_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [OUT_W-1:0]    data_o
);

    logic [OUT_W-1:0] w_ext;
    logic             w_in_fire;
    logic             w_out_fire;

    // Output (head) register: what downstream sees.
    logic             r_valid;
    logic [OUT_W-1:0] r_data;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_data (data_i),
        .i_mode (mode_t'(mode_i)),
        .o_data (w_ext)
    );

    assign w_in_fire  = valid_i && ready_o;
    assign w_out_fire = r_valid && ready_i;

`ifdef IMM_EXTEND_SKID_EN

    // Second entry catches the item accepted in the cycle downstream first
    // stalls. ready_o is taken straight from r_skid_empty, so the upstream
    // handshake never sees ready_i combinationally.
    logic             r_skid_empty;
    logic [OUT_W-1:0] r_skid_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_skid_empty <= 1'b1;
            r_skid_data  <= '0;
        end else if (!r_skid_empty) begin
            // Both entries full; input is blocked. Refill head from skid.
            if (w_out_fire) begin
                r_data       <= r_skid_data;
                r_skid_empty <= 1'b1;
            end
        end else if (w_in_fire) begin
            if (!r_valid || w_out_fire) begin
                // Head is free or leaving this edge: pass straight through.
                r_data  <= w_ext;
                r_valid <= 1'b1;
            end else begin
                // Head stalled: park the new result in the skid entry.
                r_skid_data  <= w_ext;
                r_skid_empty <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    assign ready_o = r_skid_empty;

`else

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_in_fire) begin
            r_data  <= w_ext;
            r_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    // Accept when empty, or when the held result leaves on this same edge.
    assign ready_o = !r_valid || ready_i;

`endif

    assign valid_o = r_valid;
    assign data_o  = r_data;

endmodule : imm_extend_pipe
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Self-checking bench for imm_extend_pipe. A queue-based model of
//            the stage is compared against the DUT every cycle, and directed
//            vectors pin known results. A second instance uses IN_W=12.
//            Behaviour adapts to the IMM_EXTEND_SKID_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

`ifdef IMM_EXTEND_SKID_EN
    localparam int c_DEPTH = 2;
`else
    localparam int c_DEPTH = 1;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, ready_i, ready_o, valid_o;
    logic [15:0] data_i;
    logic [1:0]  mode_i;
    logic [31:0] data_o;

    logic        valid12, ready12, ready_o12, valid_o12;
    logic [11:0] data12;
    logic [1:0]  mode12;
    logic [31:0] data_o12;

    int n_vec  = 0;
    int n_miss = 0;
    int n_out  = 0;

    logic [31:0] exp_q[$];
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    logic [31:0] last_data  = '0;

    always #5 clk_i = ~clk_i;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(32)) dut12 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid12),
        .ready_o (ready_o12),
        .data_i  (data12),
        .mode_i  (mode12),
        .valid_o (valid_o12),
        .ready_i (ready12),
        .data_o  (data_o12)
    );

    // Extension rules written as integer arithmetic on the immediate value.
    function automatic logic [31:0] model_ext(input int in_w, input logic [31:0] d,
                                              input logic [1:0] m);
        longint v, sv, r, span;
        span = longint'(1) << in_w;
        v    = longint'(d) % span;
        sv   = (v >= span / 2) ? v - span : v;
        case (m)
            2'd0:    r = v;
            2'd1:    r = sv;
            2'd2:    r = v * (longint'(1) << (32 - in_w));
            default: r = sv * 4;
        endcase
        return 32'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the queue model, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            exp_q.delete();
            stall_prev = 1'b0;
            last_data  = '0;
        end else begin
            check("valid_o", {31'b0, valid_o}, {31'b0, exp_q.size() != 0});
`ifdef IMM_EXTEND_SKID_EN
            check("ready_o", {31'b0, ready_o}, {31'b0, exp_q.size() < 2});
`else
            check("ready_o", {31'b0, ready_o}, {31'b0, (exp_q.size() == 0) || ready_i});
`endif
            if (stall_prev) check("stall_hold", data_o, stall_data);
            if (!valid_o)   check("idle_hold", data_o, last_data);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_out: got %h, expected no output", data_o);
                end else begin
                    check("data_o", data_o, exp_q.pop_front());
                end
                n_out++;
            end
            if (valid_i && ready_o)
                exp_q.push_back(model_ext(16, {16'b0, data_i}, mode_i));
            stall_prev = valid_o && !ready_i;
            stall_data = data_o;
            last_data  = data_o;
        end
    end

    // Single transfer with ready_i=1; result checked one edge later.
    task automatic one(input logic [15:0] d, input logic [1:0] m,
                       input logic [31:0] exp, input string name);
        valid_i = 1'b1; data_i = d; mode_i = m; ready_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        data_i  = 16'($urandom);
        mode_i  = 2'($urandom);
        check({name, "_valid"}, {31'b0, valid_o}, 32'd1);
        check(name, data_o, exp);
    endtask

    task automatic one12(input logic [11:0] d, input logic [1:0] m,
                         input logic [31:0] exp, input string name);
        valid12 = 1'b1; data12 = d; mode12 = m;
        @(posedge clk_i); #1;
        valid12 = 1'b0;
        check({name, "_valid"}, {31'b0, valid_o12}, 32'd1);
        check(name, data_o12, exp);
        check({name, "_model"}, data_o12, model_ext(12, {20'b0, d}, m));
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] m);
        bit acc;
        valid_i = 1'b1; data_i = d; mode_i = m;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i); #1;
            if (acc) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL push_timeout: got no accept, expected accept within 50 cycles");
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0 && !valid_o) return;
            @(posedge clk_i); #1;
        end
        n_vec++;
        n_miss++;
        $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n_acc;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0; mode_i = '0;
        valid12 = 1'b0; ready12 = 1'b1; data12 = '0; mode12 = '0;

        // Reset state
        #2 rst_i = 1'b0;
        #1;
        check("rst_valid_o", {31'b0, valid_o}, 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("rst_valid_o12", {31'b0, valid_o12}, 32'd0);
        check("rst_data_o12", data_o12, 32'd0);
        @(posedge clk_i); @(posedge clk_i); #3;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_rst", {31'b0, ready_o}, 32'd1);
        @(posedge clk_i); #1;

        // Directed vectors, 16 -> 32
        one(16'h8001, 2'b01, 32'hFFFF8001, "sign_8001");
        one(16'h8001, 2'b00, 32'h00008001, "zero_8001");
        one(16'h1234, 2'b10, 32'h12340000, "high_1234");
        one(16'hFFFF, 2'b11, 32'hFFFFFFFC, "branch_ffff");
        one(16'h0003, 2'b11, 32'h0000000C, "branch_0003");
        one(16'h7FFF, 2'b01, 32'h00007FFF, "sign_7fff");
        drain();

        // Directed vectors, 12 -> 32
        one12(12'h800, 2'b01, 32'hFFFFF800, "w12_sign_800");
        one12(12'h800, 2'b10, 32'h80000000, "w12_high_800");
        one12(12'h7FF, 2'b11, 32'h00001FFC, "w12_branch_7ff");
        one12(12'hABC, 2'b00, 32'h00000ABC, "w12_zero_abc");
        repeat (2) @(posedge clk_i);
        #1;

        // Back-to-back stream 1..8 with a three-cycle downstream stall
        base = n_out;
        fork
            begin
                for (int i = 1; i <= 8; i++) push(16'(i), 2'b01);
                valid_i = 1'b0;
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    @(posedge clk_i); #1;
                    ready_i = !(c >= 3 && c <= 5);
                end
            end
        join
        ready_i = 1'b1;
        drain();
        check("stream_count", 32'(n_out - base), 32'd8);

        // Fill with downstream stalled: accepts exactly c_DEPTH items
        ready_i = 1'b0; valid_i = 1'b1; data_i = 16'h8001; mode_i = 2'b01;
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            bit acc;
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i); #1;
            if (acc) begin n_acc++; data_i = data_i + 16'd1; end
        end
        valid_i = 1'b0;
        check("fill_count", 32'(n_acc), 32'(c_DEPTH));
        check("fill_ready_low", {31'b0, ready_o}, 32'd0);
        base = n_out;
        ready_i = 1'b1;
        drain();
        check("fill_drain_count", 32'(n_out - base), 32'(c_DEPTH));

        // Reset while full and stalled
        ready_i = 1'b0; valid_i = 1'b1; data_i = 16'hC0DE; mode_i = 2'b01;
        repeat (4) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        check("prerst_valid", {31'b0, valid_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check("midrst_valid_o", {31'b0, valid_o}, 32'd0);
        check("midrst_data_o", data_o, 32'd0);
        @(posedge clk_i); @(posedge clk_i); #3;
        ready_i = 1'b1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_midrst", {31'b0, ready_o}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("no_stale_out", {31'b0, valid_o}, 32'd0);
        end
        @(posedge clk_i); #1;

        // Traffic after reset recovers normally
        one(16'h0010, 2'b11, 32'h00000040, "post_rst_branch");
        drain();
        repeat (2) @(posedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_imm_extend_pipe
`default_nettype wire
